// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the shift-and-add multiplier and its shift-out consumer.
package mult_pkg;

  localparam int unsigned A_W = 12;
  localparam int unsigned B_W = 11;
  localparam int unsigned P_W = A_W + B_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : mult_pkg

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per cycle,
// fixed B_W-cycle latency, product held with a ready level until the next accept.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned A_W = mult_pkg::A_W,
  parameter int unsigned B_W = mult_pkg::B_W,
  parameter int unsigned P_W = mult_pkg::P_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic [P_W-1:0] z_par,
  output logic           sz
);

  localparam int unsigned CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W - 1);

  state_e           r_state;
  logic [P_W-1:0]   r_mcand;
  logic [B_W-1:0]   r_mplier;
  logic [P_W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_z_par;
  logic             r_sz;
  logic             r_busy;

  logic [P_W-1:0]   w_addend;
  logic [P_W-1:0]   w_sum;

  // Partial product for the current multiplier bit and the running sum it produces.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

  // Control FSM and datapath; the final sum is captured straight from the adder on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_z_par  <= '0;
      r_sz     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= P_W'(a);
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sz     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_z_par <= w_sum;
            r_sz    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign z_par = r_z_par;
  assign sz    = r_sz;

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: the driver queues expected products with
// their completion cycle, a negedge monitor pops and checks on each rising sz.
module tb_shift_add_mult;

  localparam int unsigned A_W = 12;
  localparam int unsigned B_W = 11;
  localparam int unsigned P_W = 23;
  localparam int          LAT = 12;  // negedge-cycle distance from drive to visible result

  typedef struct {
    logic [P_W-1:0] z;
    int             t;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic           busy;
  logic [P_W-1:0] z_par;
  logic           sz;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic           prev_sz = 1'b0;
  logic [P_W-1:0] prev_z = '0;

  shift_add_mult dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .z_par (z_par),
    .sz    (sz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one start pulse from a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb_v,
                       input bit expect_res, input logic [P_W-1:0] ez);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    if (expect_res) sb.push_back('{z: ez, t: cyc + LAT});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: compare each new product against the scoreboard and check hold while ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (sz && !prev_sz) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got z_par=%0d, expected no result (cycle %0d)", z_par, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", 32'(z_par), 32'(e.z));
          check("latency_cycle", 32'(cyc), 32'(e.t));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end else if (sz && prev_sz) begin
        check("z_par_hold", 32'(z_par), 32'(prev_z));
      end
    end
    prev_sz = sz;
    prev_z  = z_par;
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sz", 32'(sz), 32'd0);
    check("rst_z_par", 32'(z_par), 32'd0);
    rst = 1'b0;
    wait_cyc(1);

    // Basic product 3*5 with busy profile over the whole run
    issue(12'd3, 11'd5, 1'b1, 23'd15);
    check("busy_e0", 32'(busy), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("busy_e11", 32'(busy), 32'd0);
    wait_cyc(5);
    check("sz_held", 32'(sz), 32'd1);
    check("z_par_held", 32'(z_par), 32'd15);

    // Maximum operands, no truncation
    issue(12'd4095, 11'd2047, 1'b1, 23'h7FE801);
    wait_cyc(13);

    // Zero multiplicand, then 1*1
    issue(12'd0, 11'd2047, 1'b1, 23'd0);
    wait_cyc(13);
    issue(12'd1, 11'd1, 1'b1, 23'd1);
    wait_cyc(13);

    // Start during RUN is ignored: only 700 appears
    issue(12'd100, 11'd7, 1'b1, 23'd700);
    wait_cyc(4);
    a     = 12'd9;
    b     = 11'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(18);
    check("no_second_op", 32'(busy), 32'd0);

    // Reset mid-operation abandons it without a result
    issue(12'd5, 11'd5, 1'b0, 23'd0);
    wait_cyc(5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sz", 32'(sz), 32'd0);
    check("midrst_z_par", 32'(z_par), 32'd0);
    rst = 1'b0;
    wait_cyc(3);
    check("after_rst_sz", 32'(sz), 32'd0);
    issue(12'd2, 11'd2, 1'b1, 23'd4);
    wait_cyc(13);

    // Continuous start: 42 then 100, twelve cycles apart with one low cycle of sz
    a     = 12'd7;
    b     = 11'd6;
    start = 1'b1;
    sb.push_back('{z: 23'd42, t: cyc + LAT});
    sb.push_back('{z: 23'd100, t: cyc + 2 * LAT});
    @(negedge clk);
    a = 12'd10;
    b = 11'd10;
    wait_cyc(11);
    check("cont_sz_first", 32'(sz), 32'd1);
    @(negedge clk);
    check("cont_sz_gap", 32'(sz), 32'd0);
    check("cont_busy_gap", 32'(busy), 32'd1);
    start = 1'b0;
    wait_cyc(11);
    check("cont_sz_second", 32'(sz), 32'd1);
    wait_cyc(6);

    check("pending_results", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift_add_mult
